// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: sequences a DIV through an external signed divider and owns
// the HI/LO register pair. A DIV stalls the pipeline for 2+WAIT_CYCLES cycles,
// then the quotient lands in LO and the remainder in HI. MTHI/MTLO write the
// registers directly while the sequencer is idle.
//
// Handshake: div_req is a level request that is only looked at in IDLE. When it
// is accepted, stall rises combinationally in that same cycle and stays high
// until the cycle in which the new HI/LO values are visible, when it is low.
// div_start is a registered single-cycle pulse that marks the first cycle in
// which div_dividend/div_divisor carry the accepted operands.
`timescale 1ns/1ps
module hilo_div_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_req,
    input  logic [31:0] dividend_in,
    input  logic [31:0] divisor_in,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        stall,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(WAIT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   dividend_q, dividend_d;
    logic [31:0]   divisor_q, divisor_d;
    logic          div_start_q, div_start_d;
    logic          dbz_q, dbz_d;
    logic          stall_c;

    // Next-state, register updates and the combinational stall request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        div_start_d = 1'b0;
        dbz_d       = 1'b0;
        stall_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (div_req) begin
                    // A DIV always wins over MTHI/MTLO in the same cycle.
                    if (divisor_in != 32'd0) begin
                        stall_c     = 1'b1;
                        dividend_d  = dividend_in;
                        divisor_d   = divisor_in;
                        div_start_d = 1'b1;
                        state_d     = S_ISSUE;
                    end else begin
                        // Divide by zero is dropped; HI/LO keep their values.
                        dbz_d = 1'b1;
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_ISSUE: begin
                stall_c = 1'b1;
                cnt_d   = CW'(WAIT_CYCLES - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    // Divider results are taken as-is, no sign correction.
                    hi_d    = div_r;
                    lo_d    = div_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any divide in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            div_start_q <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            div_start_q <= div_start_d;
            dbz_q       <= dbz_d;
        end
    end

    assign stall        = stall_c & ~reset;
    assign div_start    = div_start_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign div_by_zero  = dbz_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign dbg_state    = state_q;

endmodule
